// File: rtl/cell_capture_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cell_capture_pkg
// Description : Shared geometry, state encoding and return-path record for
//               the Sudoku cell capture block.
// Revision    : 1.0 - initial release
// ============================================================================
package cell_capture_pkg;

    localparam int RAW_SIZE = 52;
    localparam int IMG_BITS = RAW_SIZE * RAW_SIZE;
    localparam int FB_W     = 320;
    localparam int FB_H     = 240;
    localparam int ADDR_W   = 17;
    localparam int PIX_W    = 12;
    localparam int IDX_W    = $clog2(IMG_BITS);
    localparam int RC_W     = $clog2(RAW_SIZE);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    // Travels alongside each read so the returning pixel knows where it lands
    typedef struct packed {
        logic             vld;
        logic             zero;
        logic [IDX_W-1:0] idx;
    } ret_meta_t;

endpackage
`default_nettype wire

// File: rtl/cell_capture_pix_binarize.sv
`default_nettype none
// ============================================================================
// Module      : cell_capture_pix_binarize
// Description : RGB444 pixel to ink/paper decision, ink when R+G+B < THRESH.
// Revision    : 1.0 - initial release
// ============================================================================
module cell_capture_pix_binarize
    import cell_capture_pkg::*;
#(
    parameter int THRESH = 24
) (
    input  logic [PIX_W-1:0] pix_i,
    output logic             ink_o
);

    logic [5:0] w_sum;

    always_comb begin
        w_sum = 6'(pix_i[11:8]) + 6'(pix_i[7:4]) + 6'(pix_i[3:0]);
        ink_o = (w_sum < 6'(THRESH));
    end

endmodule
`default_nettype wire

// File: rtl/cell_capture.sv
`default_nettype none
// ============================================================================
// Module      : cell_capture
// Description : Reads a 52x52 window from the frame buffer in raster order and
//               binarizes it into a flat image vector. Optional macro
//               CAPTURE_BORDER_MASK_EN clears a MASK-pixel border ring.
// Revision    : 1.0 - initial release
// ============================================================================
module cell_capture
    import cell_capture_pkg::*;
#(
    parameter int THRESH = 24,
    parameter int FB_LAT = 1,
    parameter int MASK   = 3
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [8:0]          org_x,
    input  logic [7:0]          org_y,
    output logic                busy,
    output logic                done,
    output logic                fb_rd_en,
    output logic [ADDR_W-1:0]   fb_addr,
    input  logic [PIX_W-1:0]    fb_data,
    output logic [IMG_BITS-1:0] img
);

    localparam logic [RC_W-1:0] RC_LAST   = RC_W'(RAW_SIZE - 1);
    localparam logic [1:0]      DRAIN_END = 2'(FB_LAT);
`ifdef CAPTURE_BORDER_MASK_EN
    localparam logic            MASK_EN   = 1'b1;
`else
    localparam logic            MASK_EN   = 1'b0;
`endif

    state_t              state_q, state_d;
    logic [8:0]          org_x_q;
    logic [7:0]          org_y_q;
    logic [RC_W-1:0]     r_q, c_q;
    logic [IDX_W-1:0]    idx_q;
    logic [ADDR_W-1:0]   row_base_q;
    logic [1:0]          drain_q;
    logic                fb_rd_en_q;
    logic [ADDR_W-1:0]   fb_addr_q;
    ret_meta_t           meta_q [0:FB_LAT];
    ret_meta_t           w_meta_d;
    ret_meta_t           w_ret;
    logic [IMG_BITS-1:0] img_q;

    logic [9:0]          w_col;
    logic [8:0]          w_row;
    logic                w_clip, w_border, w_zero, w_last, w_accept, w_ink;

    // ---------------------------------------------------------------- FSM
    always_ff @(posedge clk) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (start)                 state_d = ST_READ;
            ST_READ:  if (w_last)                state_d = ST_DRAIN;
            ST_DRAIN: if (drain_q == DRAIN_END)  state_d = ST_DONE;
            ST_DONE:                             state_d = ST_IDLE;
            default:                             state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        busy = (state_q != ST_IDLE);
        done = (state_q == ST_DONE);
    end

    // ---------------------------------------------------------------- issue side
    always_comb begin
        w_accept = (state_q == ST_IDLE) && start;
        w_last   = (r_q == RC_LAST) && (c_q == RC_LAST);
        w_col    = 10'(org_x_q) + 10'(c_q);
        w_row    = 9'(org_y_q) + 9'(r_q);
        w_clip   = (w_col >= 10'(FB_W)) || (w_row >= 9'(FB_H));
        w_border = (r_q < RC_W'(MASK)) || (r_q >= RC_W'(RAW_SIZE - MASK)) ||
                   (c_q < RC_W'(MASK)) || (c_q >= RC_W'(RAW_SIZE - MASK));
        w_zero   = w_clip | (MASK_EN & w_border);
        w_meta_d.vld  = (state_q == ST_READ);
        w_meta_d.zero = w_zero;
        w_meta_d.idx  = idx_q;
    end

    // The extra DRAIN cycle covers the registered read strobe ahead of the RAM
    always_ff @(posedge clk) begin
        if (rst) begin
            org_x_q    <= '0;
            org_y_q    <= '0;
            r_q        <= '0;
            c_q        <= '0;
            idx_q      <= '0;
            row_base_q <= '0;
            fb_rd_en_q <= 1'b0;
            fb_addr_q  <= '0;
            drain_q    <= '0;
        end else begin
            fb_rd_en_q <= 1'b0;
            drain_q    <= (state_q == ST_DRAIN) ? drain_q + 2'd1 : 2'd0;
            if (w_accept) begin
                org_x_q    <= org_x;
                org_y_q    <= org_y;
                r_q        <= '0;
                c_q        <= '0;
                idx_q      <= '0;
                row_base_q <= ADDR_W'(org_y * FB_W);
            end
            if (state_q == ST_READ) begin
                fb_rd_en_q <= ~w_clip;
                if (!w_clip) fb_addr_q <= row_base_q + ADDR_W'(w_col);
                idx_q <= idx_q + IDX_W'(1);
                if (c_q == RC_LAST) begin
                    c_q        <= '0;
                    r_q        <= r_q + RC_W'(1);
                    row_base_q <= row_base_q + ADDR_W'(FB_W);
                end else begin
                    c_q <= c_q + RC_W'(1);
                end
            end
        end
    end

    // ---------------------------------------------------------------- return side
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i <= FB_LAT; i++) meta_q[i] <= '0;
        end else begin
            meta_q[0] <= w_meta_d;
            for (int i = 1; i <= FB_LAT; i++) meta_q[i] <= meta_q[i-1];
        end
    end

    assign w_ret = meta_q[FB_LAT];

    cell_capture_pix_binarize #(
        .THRESH (THRESH)
    ) u_pix_binarize (
        .pix_i  (fb_data),
        .ink_o  (w_ink)
    );

    always_ff @(posedge clk) begin
        if (rst)            img_q <= '0;
        else if (w_accept)  img_q <= '0;
        else if (w_ret.vld) img_q[w_ret.idx] <= w_ink & ~w_ret.zero;
    end

    assign fb_rd_en = fb_rd_en_q;
    assign fb_addr  = fb_addr_q;
    assign img      = img_q;

endmodule
`default_nettype wire

// File: doc/cell_capture.md
Name: cell_capture

Overview:
- Upstream feeder of the 52x52-to-28x28 downsampler.
- On `start`, reads one 52x52 Sudoku cell window from the pixel frame buffer (synchronous-read RAM) in raster order and binarizes each pixel to ink (1) or paper (0).
- Assembles the result into the flat 2704-bit image vector the downsampler consumes.
- Start/busy/done handshake; the image is held stable between captures.

Parameters:
- RAW_SIZE, 52, window edge in pixels; image is RAW_SIZE*RAW_SIZE bits.
- FB_W, 320, frame buffer width in pixels.
- FB_H, 240, frame buffer height in pixels.
- ADDR_W, 17, frame buffer address width; must satisfy 2^ADDR_W >= FB_W*FB_H.
- PIX_W, 12, pixel width, RGB444 as {R[11:8],G[7:4],B[3:0]}.
- THRESH, 24, ink threshold on R+G+B (0..45).
- FB_LAT, 1, frame buffer read latency in cycles (1..3).
- MASK, 3, border width in pixels cleared when the optional feature is enabled.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset; synchronous, active-high.
- start  in  1  capture request; sampled only in IDLE.
- org_x  in  9  window left column in frame coordinates; latched on accepted start.
- org_y  in  8  window top row; latched on accepted start.
- busy  out  1  high from the cycle after an accepted start until done.
- done  out  1  single-cycle pulse when img is complete.
- fb_rd_en  out  1  frame buffer read strobe.
- fb_addr  out  ADDR_W  frame buffer read address, (org_y+r)*FB_W + org_x + c.
- fb_data  in  PIX_W  read data, valid FB_LAT cycles after fb_rd_en.
- img  out  RAW_SIZE*RAW_SIZE  binarized window; bit r*RAW_SIZE+c = pixel (row r, col c).

Behaviour:
- Reset: state IDLE; busy=0, done=0, fb_rd_en=0, fb_addr=0, img=all 0; all counters and delay pipes cleared. Reset mid-capture aborts the capture; no done pulse.
- States: IDLE, READ, DRAIN, DONE.
- IDLE: on start=1, latch org_x/org_y, clear img, reset r=c=0, go to READ.
- READ: one issue per cycle in raster order (c fastest).
  - fb_addr is built incrementally: a row-base register adds FB_W per row, plus a column offset. No multiplier.
  - After issuing (51,51), go to DRAIN.
- DRAIN: wait FB_LAT cycles for the last return, then go to DONE.
- DONE: done=1 for exactly one cycle, then IDLE.
- Done timing: asserted exactly RAW_SIZE*RAW_SIZE + FB_LAT + 1 cycles after the edge that sampled start (2706 with defaults).
- Return path: (r,c) index and a "clipped" flag travel through an FB_LAT-deep delay pipe aligned with fb_data.
- Ink rule: ink = (R+G+B) < THRESH, summed in 6-bit unsigned arithmetic. Result written to img[r*RAW_SIZE+c].
- Clipping: pixels with org_x+c >= FB_W or org_y+r >= FB_H get fb_rd_en=0 and bit 0. Slot timing is unchanged and the address never wraps into the next row.
- busy: high in READ, DRAIN and DONE.
- start while busy: ignored, not queued.
- start in the same cycle as done: ignored. A new start is accepted from the following IDLE cycle.
- img: changes only during READ/DRAIN; otherwise holds the last capture.

Optional Feature:
- Macro CAPTURE_BORDER_MASK_EN.
- Defined: bits with r<MASK, r>=RAW_SIZE-MASK, c<MASK or c>=RAW_SIZE-MASK are forced to 0. This suppresses Sudoku grid lines. Reads and timing are unchanged.
- Undefined: every pixel is binarized by the ink rule alone.

Decomposition:
- Shared header package: RAW_SIZE, FB_W, FB_H, ADDR_W, PIX_W, and the state encodings (IDLE=0, READ=1, DRAIN=2, DONE=3).
- One sub-module, pix_binarize: combinational RGB444-to-ink comparator, parameterized by THRESH. Instantiated once on the return path.

Test Plan:
- All-white frame (0xFFF), start with org (0,0) -> done exactly 2706 cycles after start; img all 0; busy high throughout.
- Frame pixel = 0x000 only at (10+5, 20+7); start with org_x=20, org_y=10 -> img bit 5*52+7 = 1, all other bits 0; first fb_addr = 10*320+20 = 3220.
- org_x=300, org_y=200 on an all-black frame -> bits with c>=20 or r>=40 are 0 with fb_rd_en low; the rest are 1.
- Second start pulsed mid-capture, and again coincident with done -> only one done pulse; img unchanged until a later start in IDLE.
- rst asserted at cycle 1000 of a capture -> next cycle busy=0, img=0, no done; a fresh capture then completes normally.
- All-black frame, org (0,0): with CAPTURE_BORDER_MASK_EN defined, outer 3-pixel ring = 0 and interior 46x46 = 1; without it, all 2704 bits = 1.
